key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; successor to the single-key 20 ms scan/toggle block.
- Per channel it provides:
  - input synchronisation
  - tick-based debounce with a consecutive-sample stability count
  - debounced level, press/release strobes, a long-press strobe
  - a per-channel LED toggle register
- Sits between board key pins and user logic/LEDs.

Parameters:
- NUM_KEYS, 2: number of independent key channels (1..32).
- SAMPLE_CYCLES, 1000000: clk cycles per sample tick (20 ms at 50 MHz); must be >= 2.
- STABLE_SAMPLES, 3: consecutive ticks a new level must hold before it is accepted; must be >= 1.
- LONG_SAMPLES, 50: ticks a key must stay pressed to raise key_long (1 s default); must be > STABLE_SAMPLES.
- ACTIVE_LOW, 1: 1 = key_in low means pressed; 0 = high means pressed.
- LED_INIT, 1: reset value of every led_out bit.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: synchronous, active-high reset.
- key_in, input, NUM_KEYS: raw asynchronous key pins.
- key_level, output, NUM_KEYS: debounced state, 1 = pressed.
- key_press, output, NUM_KEYS: 1-cycle strobe when key_level rises.
- key_release, output, NUM_KEYS: 1-cycle strobe when key_level falls.
- key_long, output, NUM_KEYS: 1-cycle strobe once per press after LONG_SAMPLES ticks held.
- led_out, output, NUM_KEYS: per-channel toggle register.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - tick counter = 0
  - synchronisers, stable counters, hold counters = 0
  - key_level = 0; key_press, key_release, key_long = 0
  - led_out = {NUM_KEYS{LED_INIT}}
  - Reset mid-press discards all channel state. After rst deasserts, a held key is re-qualified from scratch and produces a fresh key_press.
- Synchroniser:
  - two flops per bit, then polarity normalise: s = ACTIVE_LOW ? ~sync2 : sync2.
  - The synchroniser flops reset to the idle level (1 if ACTIVE_LOW).
- Tick generator:
  - one shared counter 0..SAMPLE_CYCLES-1, wraps to 0.
  - internal tick = 1 for the single cycle where count == SAMPLE_CYCLES-1.
  - width = clog2(SAMPLE_CYCLES).
- Per-channel debounce, evaluated only on tick cycles:
  - if s == key_level: stable_cnt <= 0.
  - else if stable_cnt == STABLE_SAMPLES-1: key_level <= s and stable_cnt <= 0.
  - else: stable_cnt <= stable_cnt+1.
  - With STABLE_SAMPLES=1, the level is accepted on the first differing tick.
  - Any glitch that returns to key_level before acceptance resets the count.
- Strobes:
  - key_press and key_release are registered and assert in the same cycle key_level updates (the cycle after the accepting tick edge).
  - High exactly 1 cycle; never both set for one channel.
- Long press:
  - hold_cnt increments on each tick while key_level=1 and saturates at LONG_SAMPLES.
  - key_long pulses for 1 cycle when hold_cnt transitions LONG_SAMPLES-1 -> LONG_SAMPLES.
  - hold_cnt clears when key_level=0.
  - Exactly one key_long per press, regardless of hold length.
- LED:
  - led_out[i] toggles on the edge where key_press[i] is high; it is unaffected by release or long press.
  - Multiple channels pressing simultaneously each toggle their own bit independently.
- Latency, raw edge to key_level:
  - 2 sync cycles, plus the wait to the next tick (0..SAMPLE_CYCLES-1), plus (STABLE_SAMPLES-1)*SAMPLE_CYCLES, plus 1 register cycle.
- All channels share the tick, so accepted transitions on different channels align to tick boundaries.
- No combinational path from key_in to any output.

Test Plan:
All tests use SAMPLE_CYCLES=4, STABLE_SAMPLES=3, LONG_SAMPLES=6, NUM_KEYS=2, ACTIVE_LOW=1, LED_INIT=1.
1. Reset behaviour:
   - Stimulus: rst=1 for 3 cycles with key_in=2'b00 (both pressed), then release rst.
   - Response: during reset all strobes and key_level are 0 and led_out=2'b11. After release, key_level=2'b11 and key_press=2'b11 one cycle within 16 cycles. led_out then becomes 2'b00.
2. Clean press:
   - Stimulus: drive key_in[0] 1->0 and hold.
   - Response: key_level[0] rises after exactly 3 accepting ticks. key_press[0] is high for 1 cycle. led_out[0] toggles 1->0. Channel 1 is unchanged.
3. Glitch rejection:
   - Stimulus: key_in[0] low for 2 ticks, high for 1 tick, then low for 2 ticks.
   - Response: key_level[0] stays 0; no strobe; led_out unchanged.
4. Long press:
   - Stimulus: hold key_in[1]=0 for 20 ticks, then release.
   - Response: key_long[1] pulses once, 6 ticks after key_level[1] rises. key_release[1] fires 3 ticks after the release. A second 20-tick hold gives exactly one more key_long.
5. Simultaneous keys:
   - Stimulus: both keys pressed on the same cycle.
   - Response: key_press=2'b11 in the same cycle and both led_out bits toggle.
   - Stimulus: then release key 0 only.
   - Response: key_release=2'b01; key_level=2'b10.
6. Reset mid-press:
   - Stimulus: assert rst for 1 cycle while key 0 is pressed and debounced.
   - Response: key_level[0] goes to 0 and led_out[0] goes to 1. With key_in still held, a new key_press[0] appears after re-qualification.

Source files
------------

// File: rtl/key_if.sv
// Key channel bundle: raw pins in, debounced level/strobes/LED out.
// master = board/user side, slave = the conditioner.
interface key_if #(
    parameter int unsigned NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;
    logic [NUM_KEYS-1:0] led_out;

    modport master (
        output key_in,
        input  key_level, key_press, key_release, key_long, led_out
    );

    modport slave (
        input  key_in,
        output key_level, key_press, key_release, key_long, led_out
    );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: sync, tick-based debounce, press/release/long strobes
// and a per-channel LED toggle register.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS       = 2,
    parameter int unsigned SAMPLE_CYCLES  = 1000000,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned LONG_SAMPLES   = 50,
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter bit          LED_INIT       = 1'b1
) (
    input logic  clk,
    input logic  rst,
    key_if.slave keys
);
    localparam int unsigned CntW  = $clog2(SAMPLE_CYCLES);
    localparam int unsigned StW   = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
    localparam int unsigned HoldW = $clog2(LONG_SAMPLES + 1);

    localparam logic [NUM_KEYS-1:0] SyncIdle = {NUM_KEYS{ACTIVE_LOW}};
    localparam logic [NUM_KEYS-1:0] LedReset = {NUM_KEYS{LED_INIT}};
    localparam logic [CntW-1:0]     TickLast = CntW'(SAMPLE_CYCLES - 1);
    localparam logic [StW-1:0]      StLast   = StW'(STABLE_SAMPLES - 1);
    localparam logic [HoldW-1:0]    HoldMax  = HoldW'(LONG_SAMPLES);
    localparam logic [HoldW-1:0]    HoldPre  = HoldW'(LONG_SAMPLES - 1);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q, s;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    logic [NUM_KEYS-1:0] led_q, led_d;
    logic [StW-1:0]      stable_q [NUM_KEYS];
    logic [StW-1:0]      stable_d [NUM_KEYS];
    logic [HoldW-1:0]    hold_q   [NUM_KEYS];
    logic [HoldW-1:0]    hold_d   [NUM_KEYS];

    assign tick = (cnt_q == TickLast);
    assign s    = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CntW'(1);
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        led_d     = led_q ^ press_q;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            stable_d[i] = stable_q[i];
            hold_d[i]   = level_q[i] ? hold_q[i] : '0;
            if (tick) begin
                if (s[i] == level_q[i]) begin
                    stable_d[i] = '0;
                end else if (stable_q[i] == StLast) begin
                    level_d[i]   = s[i];
                    stable_d[i]  = '0;
                    press_d[i]   = s[i];
                    release_d[i] = ~s[i];
                end else begin
                    stable_d[i] = stable_q[i] + StW'(1);
                end
                // Saturating hold count; the strobe fires only on the final step.
                if (level_q[i] && (hold_q[i] != HoldMax)) begin
                    hold_d[i] = hold_q[i] + HoldW'(1);
                    long_d[i] = (hold_q[i] == HoldPre);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sync1_q   <= SyncIdle;
            sync2_q   <= SyncIdle;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            led_q     <= LedReset;
            stable_q  <= '{default: '0};
            hold_q    <= '{default: '0};
        end else begin
            cnt_q     <= cnt_d;
            sync1_q   <= keys.key_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            led_q     <= led_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
        end
    end

    assign keys.key_level   = level_q;
    assign keys.key_press   = press_q;
    assign keys.key_release = release_q;
    assign keys.key_long    = long_q;
    assign keys.led_out     = led_q;
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed phases plus random bouncing, checked per cycle
// against a window-based reference model through an expectation queue.
module tb_key_debounce_multi;
    localparam int NK = 2;
    localparam int SC = 4;
    localparam int SS = 3;
    localparam int LS = 6;

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] led;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_multi #(
        .NUM_KEYS      (NK),
        .SAMPLE_CYCLES (SC),
        .STABLE_SAMPLES(SS),
        .LONG_SAMPLES  (LS),
        .ACTIVE_LOW    (1'b1),
        .LED_INIT      (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .keys(kif)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_long_cnt = 0, exp_press_cnt = 0;
    int   dut_long_cnt = 0, dut_press_cnt = 0;

    // Reference model state: tick samples per channel, raw pin history, tick phase.
    logic [NK-1:0] m_level, m_press, m_led, m_s;
    logic [NK-1:0] n_level, n_press, n_rel, n_lng;
    logic [NK-1:0] m_raw[$];
    bit            m_hist[NK][$];
    int            m_held[NK];
    int            m_edges;
    bit            m_tick, all_diff;
    exp_t          m_e;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_level = '0;
                m_press = '0;
                m_led   = 2'b11;
                m_edges = 0;
                m_raw.delete();
                for (int ch = 0; ch < NK; ch++) begin
                    m_held[ch] = 0;
                    m_hist[ch].delete();
                end
                m_e = '{level: '0, press: '0, rel: '0, lng: '0, led: 2'b11};
            end else begin
                // The pin value seen by the debouncer was captured two edges ago.
                m_s     = (m_raw.size() >= 2) ? ~m_raw[m_raw.size()-2] : '0;
                m_tick  = (m_edges % SC) == SC - 1;
                m_edges++;
                n_level = m_level;
                n_press = '0;
                n_rel   = '0;
                n_lng   = '0;
                for (int ch = 0; ch < NK; ch++) begin
                    if (m_tick) begin
                        if (m_level[ch]) begin
                            m_held[ch]++;
                            if (m_held[ch] == LS) n_lng[ch] = 1'b1;
                        end
                        m_hist[ch].push_back(m_s[ch]);
                        if (m_hist[ch].size() > SS) void'(m_hist[ch].pop_front());
                        if (m_hist[ch].size() == SS) begin
                            all_diff = 1'b1;
                            for (int k = 0; k < SS; k++)
                                if (m_hist[ch][k] == m_level[ch]) all_diff = 1'b0;
                            if (all_diff) begin
                                n_level[ch] = ~m_level[ch];
                                n_press[ch] = n_level[ch];
                                n_rel[ch]   = ~n_level[ch];
                            end
                        end
                    end
                    if (!m_level[ch]) m_held[ch] = 0;
                end
                m_led   = m_led ^ m_press;
                m_level = n_level;
                m_press = n_press;
                m_raw.push_back(kif.key_in);
                if (m_raw.size() > 2) void'(m_raw.pop_front());
                exp_long_cnt  += $countones(n_lng);
                exp_press_cnt += $countones(n_press);
                m_e = '{level: n_level, press: n_press, rel: n_rel, lng: n_lng, led: m_led};
            end
            exp_q.push_back(m_e);
        end
    end

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("key_level",   kif.key_level,   mon_e.level);
                chk("key_press",   kif.key_press,   mon_e.press);
                chk("key_release", kif.key_release, mon_e.rel);
                chk("key_long",    kif.key_long,    mon_e.lng);
                chk("led_out",     kif.led_out,     mon_e.led);
                dut_long_cnt  += $countones(kif.key_long);
                dut_press_cnt += $countones(kif.key_press);
            end
        end
    end

    task automatic hold(input logic [NK-1:0] v, input int cycles);
        kif.key_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    logic [NK-1:0] r_tgt;
    initial begin
        rst        = 1'b1;
        kif.key_in = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(2'b00, 24);
        // Release both, then clean press on key 0.
        hold(2'b11, 24);
        hold(2'b10, 24);
        hold(2'b11, 24);
        // Glitch on key 0: 2 ticks low, 1 high, 2 low.
        hold(2'b10, 2 * SC);
        hold(2'b11, SC);
        hold(2'b10, 2 * SC);
        hold(2'b11, 24);
        // Two long presses on key 1.
        hold(2'b01, 20 * SC);
        hold(2'b11, 24);
        hold(2'b01, 20 * SC);
        hold(2'b11, 24);
        // Simultaneous press, then release key 0 only.
        hold(2'b00, 24);
        hold(2'b01, 24);
        hold(2'b11, 24);
        // Reset while key 0 is debounced and held.
        hold(2'b10, 24);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(2'b10, 30);
        hold(2'b11, 24);
        // Random bouncing with occasional resets.
        for (int seg = 0; seg < 70; seg++) begin
            r_tgt = kif.key_in ^ 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 5)) begin
                kif.key_in = 2'($urandom);
                @(negedge clk);
            end
            hold(r_tgt, $urandom_range(2, 70));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        hold(2'b11, 40);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        total++;
        if (dut_long_cnt != exp_long_cnt) begin
            bad++;
            $display("FAIL long_count: got %0d want %0d", dut_long_cnt, exp_long_cnt);
        end
        total++;
        if (dut_press_cnt != exp_press_cnt) begin
            bad++;
            $display("FAIL press_count: got %0d want %0d", dut_press_cnt, exp_press_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
